core_imem_responder: RTL and testbench
======================================

CORE_IMEM_RESPONDER -- requirements
Module: core_imem_responder

Interface
REQ-001 Parameter MEM_BASE, default 64'h80000000, byte address of first memory word.
REQ-002 Parameter MEM_WORDS, default 1024, number of 64-bit words, power of two.
REQ-003 Parameter WAIT_CYCLES, default 0, idle cycles between request and grant, 0..15.
REQ-004 g_clk  in  1  global clock; all state on rising edge.
REQ-005 g_reset  in  1  synchronous active-high reset.
REQ-006 imem_req  in  1  fetch request.
REQ-007 imem_addr  in  64  request byte address.
REQ-008 imem_gnt  out  1  request accepted this cycle.
REQ-009 imem_err  out  1  response error, valid cycle after grant.
REQ-010 imem_rdata  out  64  response data, valid cycle after grant.
REQ-011 ld_en  in  1  backdoor preload write strobe.
REQ-012 ld_idx  in  log2(MEM_WORDS)  preload word index.
REQ-013 ld_data  in  64  preload word.

Function
REQ-014 Request fires when imem_req && imem_gnt in the same cycle; imem_gnt is combinational from imem_req and FSM state.
REQ-015 FSM states: IDLE, WAIT; IDLE with imem_req and WAIT_CYCLES==0 -> grant same cycle, stay IDLE.
REQ-016 IDLE with imem_req and WAIT_CYCLES>0 -> no grant, load wait counter with WAIT_CYCLES-1, go WAIT.
REQ-017 WAIT: counter decrements each cycle; at zero with imem_req high, grant and return to IDLE.
REQ-018 imem_req low in WAIT abandons the request: no grant, return to IDLE next cycle, no response.
REQ-019 imem_addr is sampled only in the grant cycle; changes before grant are legal and take effect.
REQ-020 Address aligned down to 8 bytes; addr[2:0] ignored; word index = (addr-MEM_BASE)>>3.
REQ-021 imem_err=1 when addr < MEM_BASE or addr >= MEM_BASE+8*MEM_WORDS, unsigned 64-bit compare, no wrap.
REQ-022 On error imem_rdata SHALL be 64'b0; otherwise the addressed word.
REQ-023 imem_rdata/imem_err are registered, updated only in the cycle after a grant and held otherwise.
REQ-024 Back-to-back grants with WAIT_CYCLES==0 give one response per cycle, no bubbles.
REQ-025 ld_en writes ld_data to word ld_idx at the clock edge; a same-cycle grant to that index returns the old word.

Reset
REQ-026 g_reset: FSM->IDLE, counter->0, imem_rdata->0, imem_err->0; imem_gnt is 0 during reset.
REQ-027 Reset mid-WAIT drops the pending request with no response; the memory array is not reset.

Configuration
REQ-028 Macro CORE_IMEM_RAND_STALL_EN defined: a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle.
REQ-029 With the macro, each request adds LFSR[1:0] extra wait cycles to WAIT_CYCLES, sampled on IDLE->WAIT or IDLE grant decision.
REQ-030 Without the macro, latency is exactly WAIT_CYCLES and no LFSR logic exists.

Structure
REQ-031 The address width, data width and the IDLE/WAIT state encodings belong in the shared core_common package and header.
REQ-032 The memory array is one sub-module, core_imem_sram: single write port, single registered read port.

Verification
REQ-033 WAIT_CYCLES=0; preload idx0=64'h0011223344556677; req addr 0x80000004 -> gnt same cycle; next cycle rdata=64'h0011223344556677, err=0.
REQ-034 WAIT_CYCLES=3; req held from cycle 0 -> gnt only in cycle 3; response in cycle 4.
REQ-035 Req addr 0x7FFFFFF8 and then 0x80002000 (MEM_WORDS=1024) -> both granted; err=1 and rdata=0 for each.
REQ-036 WAIT_CYCLES=2; req high 1 cycle then low -> no gnt, no response; rdata and err keep their previous values.
REQ-037 Reset asserted in WAIT -> next cycle state IDLE, gnt=0, rdata=0, err=0; preloaded data survives reset.
REQ-038 Macro defined, 1000 requests with random req drops -> every grant latency in [WAIT_CYCLES, WAIT_CYCLES+3]; data matches the preload model.

Source files
------------

// File: rtl/core_common_pkg.sv
// Shared core definitions: bus widths and the fetch-responder FSM state encoding.
package core_common_pkg;

    localparam int XLEN   = 64;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } imem_state_t;

endpackage

// File: rtl/core_imem_sram.sv
// Instruction memory array: one write port and one registered read port.
module core_imem_sram
    import core_common_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read happens before the same-edge write lands, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (re) begin
            r_q <= r_mem[raddr];
        end
    end

    assign rdata = r_q;

endmodule

// File: rtl/core_imem_responder.sv
// Instruction-fetch responder with optional per-request random stall (macro CORE_IMEM_RAND_STALL_EN).
module core_imem_responder
    import core_common_pkg::*;
#(
    parameter logic [XLEN-1:0] MEM_BASE    = 64'h80000000,
    parameter int              MEM_WORDS   = 1024,
    parameter int              WAIT_CYCLES = 0,
    localparam int             IDX_W       = $clog2(MEM_WORDS)
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              imem_req,
    input  logic [XLEN-1:0]   imem_addr,
    output logic              imem_gnt,
    output logic              imem_err,
    output logic [DATA_W-1:0] imem_rdata,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data
);

    // Widened by one bit so the upper bound cannot wrap near the top of the address space.
    localparam logic [XLEN:0] MEM_LIMIT = {1'b0, MEM_BASE} + ((XLEN+1)'(MEM_WORDS) << 3);

    imem_state_t       r_state;
    imem_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_wait_total;
    logic              w_addr_err;
    logic [IDX_W-1:0]  w_idx;
    logic              r_err;
    logic [DATA_W-1:0] w_sram_q;

`ifdef CORE_IMEM_RAND_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_wait_total = CNT_W'(WAIT_CYCLES) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_wait_total = CNT_W'(WAIT_CYCLES);
`endif

    assign w_addr_err = (imem_addr < MEM_BASE) || ({1'b0, imem_addr} >= MEM_LIMIT);
    assign w_idx      = IDX_W'((imem_addr - MEM_BASE) >> 3);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        imem_gnt    = 1'b0;
        if (!g_reset) begin
            case (r_state)
                ST_IDLE: begin
                    if (imem_req) begin
                        if (w_wait_total == '0) begin
                            imem_gnt = 1'b1;
                        end else begin
                            w_cnt_nxt   = w_wait_total - 1'b1;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!imem_req) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (r_cnt == '0) begin
                        imem_gnt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_err <= 1'b0;
        end else if (imem_gnt) begin
            r_err <= w_addr_err;
        end
    end

    core_imem_sram #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_sram (
        .clk   (g_clk),
        .rst   (g_reset),
        .we    (ld_en),
        .waddr (ld_idx),
        .wdata (ld_data),
        .re    (imem_gnt && !w_addr_err),
        .raddr (w_idx),
        .rdata (w_sram_q)
    );

    // An errored response forces zero data; the held SRAM word is masked, not overwritten.
    assign imem_err   = r_err;
    assign imem_rdata = r_err ? '0 : w_sram_q;

endmodule

// File: tb/tb_core_imem_responder.sv
// Directed bench for core_imem_responder: three instances with WAIT_CYCLES of 0, 3 and 2.
module tb_core_imem_responder;

`ifdef CORE_IMEM_RAND_STALL_EN
    localparam int XTRA  = 3;
    localparam int NRAND = 1000;
`else
    localparam int XTRA  = 0;
    localparam int NRAND = 40;
`endif

    logic        g_clk;
    logic        g_reset;
    logic        req   [3];
    logic [63:0] addr  [3];
    logic        gnt   [3];
    logic        err   [3];
    logic [63:0] rdata [3];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [63:0] ld_data;

    logic [63:0] mem_m [1024];
    int n_vec = 0;
    int n_mis = 0;

    core_imem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .g_clk(g_clk), .g_reset(g_reset), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_gnt(gnt[0]), .imem_err(err[0]), .imem_rdata(rdata[0]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    core_imem_responder #(.WAIT_CYCLES(3)) u_dut_w3 (
        .g_clk(g_clk), .g_reset(g_reset), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_gnt(gnt[1]), .imem_err(err[1]), .imem_rdata(rdata[1]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    core_imem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
        .g_clk(g_clk), .g_reset(g_reset), .imem_req(req[2]), .imem_addr(addr[2]),
        .imem_gnt(gnt[2]), .imem_err(err[2]), .imem_rdata(rdata[2]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [63:0] a_of(input int idx);
        return 64'h8000_0000 + 64'(idx) * 64'd8;
    endfunction

    task automatic load(input int idx, input logic [63:0] data);
        ld_en   = 1'b1;
        ld_idx  = 10'(idx);
        ld_data = data;
        mem_m[idx] = data;
        @(negedge g_clk);
        ld_en = 1'b0;
        #1;
    endtask

    // Holds the request until granted, checks latency window, then checks the response.
    task automatic do_req(input int d, input logic [63:0] a, input logic [63:0] exp_d,
                          input logic exp_e, input int pre);
        int lat;
        int lo;
        int hi;
        int clamp;
        lo = wait_of(d) - pre;
        hi = wait_of(d) + XTRA - pre;
        req[d]  = 1'b1;
        addr[d] = a;
        lat = 0;
        #1;
        while (!gnt[d] && lat < 40) begin
            @(negedge g_clk);
            lat++;
            #1;
        end
        clamp = (lat < lo) ? lo : ((lat > hi) ? hi : lat);
        chk("grant_latency", 64'(lat), 64'(clamp));
        @(negedge g_clk);
        req[d] = 1'b0;
        #1;
        chk("resp_rdata", rdata[d], exp_d);
        chk("resp_err", 64'(err[d]), 64'(exp_e));
    endtask

    // One-cycle request then drop: must never be granted.
    task automatic drop_req(input int d, input logic [63:0] a);
        req[d]  = 1'b1;
        addr[d] = a;
        #1;
        chk("drop_no_gnt_c0", 64'(gnt[d]), 64'd0);
        @(negedge g_clk);
        req[d] = 1'b0;
        #1;
        chk("drop_no_gnt_c1", 64'(gnt[d]), 64'd0);
        @(negedge g_clk);
        #1;
    endtask

    initial begin
        logic [63:0] held_d;
        for (int d = 0; d < 3; d++) begin
            req[d]  = 1'b0;
            addr[d] = 64'h8000_0000;
        end
        ld_en   = 1'b0;
        ld_idx  = '0;
        ld_data = '0;
        g_reset = 1'b1;
        req[0]  = 1'b1;
        @(negedge g_clk);
        @(negedge g_clk);
        #1;
        chk("reset_gnt_low", 64'(gnt[0]), 64'd0);
        for (int d = 0; d < 3; d++) begin
            chk("reset_rdata", rdata[d], 64'd0);
            chk("reset_err", 64'(err[d]), 64'd0);
        end
        g_reset = 1'b0;
        req[0]  = 1'b0;
        @(negedge g_clk);
        #1;

        load(0, 64'h0011223344556677);
        for (int i = 1; i < 16; i++) begin
            load(i, 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | 64'(i));
        end
        load(1023, 64'hFEED_FACE_CAFE_BEEF);

`ifndef CORE_IMEM_RAND_STALL_EN
        req[0]  = 1'b1;
        addr[0] = 64'h8000_0004;
        #1;
        chk("w0_same_cycle_gnt", 64'(gnt[0]), 64'd1);
        @(negedge g_clk);
        req[0] = 1'b0;
        #1;
        chk("w0_first_rdata", rdata[0], 64'h0011223344556677);
        chk("w0_first_err", 64'(err[0]), 64'd0);

        req[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            addr[0] = a_of(i);
            #1;
            chk("b2b_gnt", 64'(gnt[0]), 64'd1);
            @(negedge g_clk);
            #1;
            chk("b2b_rdata", rdata[0], mem_m[i]);
        end
        req[0] = 1'b0;

        ld_en   = 1'b1;
        ld_idx  = 10'd5;
        ld_data = 64'h5555_AAAA_5555_AAAA;
        req[0]  = 1'b1;
        addr[0] = a_of(5);
        #1;
        chk("collide_gnt", 64'(gnt[0]), 64'd1);
        @(negedge g_clk);
        ld_en  = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("collide_old_word", rdata[0], mem_m[5]);
        mem_m[5] = 64'h5555_AAAA_5555_AAAA;
`endif
        do_req(0, a_of(5), mem_m[5], 1'b0, 0);
        do_req(0, 64'h8000_1FF8, 64'hFEED_FACE_CAFE_BEEF, 1'b0, 0);
        do_req(0, 64'h8000_0017, mem_m[2], 1'b0, 0);
        do_req(0, 64'h7FFF_FFF8, 64'd0, 1'b1, 0);
        do_req(0, 64'h8000_2000, 64'd0, 1'b1, 0);
        repeat (2) @(negedge g_clk);
        #1;
        chk("err_hold_rdata", rdata[0], 64'd0);
        chk("err_hold_err", 64'(err[0]), 64'd1);
        do_req(0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b1, 0);

        do_req(1, a_of(1), mem_m[1], 1'b0, 0);
        req[1]  = 1'b1;
        addr[1] = a_of(7);
        @(negedge g_clk);
        #1;
        chk("w3_early_no_gnt", 64'(gnt[1]), 64'd0);
        do_req(1, a_of(2), mem_m[2], 1'b0, 1);

        do_req(2, a_of(3), mem_m[3], 1'b0, 0);
        drop_req(2, a_of(9));
        repeat (3) begin
            chk("abandon_no_gnt", 64'(gnt[2]), 64'd0);
            chk("abandon_hold_rdata", rdata[2], mem_m[3]);
            chk("abandon_hold_err", 64'(err[2]), 64'd0);
            @(negedge g_clk);
            #1;
        end

        held_d = 64'd0;
        for (int n = 0; n < NRAND; n++) begin
            int idx;
            if ($urandom_range(0, 3) == 0) begin
                drop_req(1, a_of(int'($urandom_range(0, 15))));
            end
            idx = int'($urandom_range(0, 16));
            if (idx == 16) begin
                do_req(1, 64'h8000_2008, 64'd0, 1'b1, 0);
            end else begin
                do_req(1, a_of(idx) | 64'($urandom_range(0, 7)), mem_m[idx], 1'b0, 0);
                held_d = mem_m[idx];
            end
        end
        do_req(1, a_of(6), mem_m[6], 1'b0, 0);

        req[1]  = 1'b1;
        addr[1] = a_of(4);
        @(negedge g_clk);
        g_reset = 1'b1;
        #1;
        chk("rst_in_wait_gnt", 64'(gnt[1]), 64'd0);
        @(negedge g_clk);
        g_reset = 1'b0;
        req[1]  = 1'b0;
        #1;
        chk("rst_in_wait_gnt_after", 64'(gnt[1]), 64'd0);
        chk("rst_in_wait_rdata", rdata[1], 64'd0);
        chk("rst_in_wait_err", 64'(err[1]), 64'd0);
        repeat (4) @(negedge g_clk);
        #1;
        chk("rst_no_late_resp", rdata[1], 64'd0);
        do_req(1, a_of(0), 64'h0011223344556677, 1'b0, 0);
        do_req(0, a_of(1023), 64'hFEED_FACE_CAFE_BEEF, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
